fwd_hazard_ctrl: RTL
====================

# fwd_hazard_ctrl

Parametrised forwarding and hazard controller for the five-stage pipeline; it replaces the fixed two-operand, 3-bit forwarding unit. For `NUM_SRC` source operands it generates EX-stage forwarding selects and detects load-use hazards. It also sequences a multi-cycle execute unit (multiply/divide) through a stall FSM and keeps a saturating stall-cycle counter. It sits beside the ID/EX register and drives the PC, IF/ID and ID/EX hold and bubble controls.

## Interface
- `AW`, 3: register address width.
- `NUM_SRC`, 2: source operands per instruction (≥1).
- `MC_LAT`, 4: multi-cycle unit latency in cycles (≥2).
- `CNT_W`, 16: stall counter width.

- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ifid_src`  in  NUM_SRC*AW  decode-stage source registers; operand i at [i*AW +: AW].
- `ifid_src_vld`  in  NUM_SRC  per-operand "actually read" flags.
- `idex_src`  in  NUM_SRC*AW  execute-stage source registers.
- `idex_src_vld`  in  NUM_SRC  execute-stage read flags.
- `idex_rd`, `exmem_rd`, `memwb_rd`  in  AW each  destination registers.
- `idex_regWrite`, `exmem_regWrite`, `memwb_regWrite`  in  1 each  write enables.
- `idex_memRead`  in  1  ID/EX holds a load.
- `idex_mc_start`  in  1  ID/EX holds a multi-cycle op.
- `fwd_sel`  out  NUM_SRC*2  per operand: 00 register file, 10 EX/MEM, 01 MEM/WB.
- `stall`  out  1  hold PC and IF/ID.
- `hold_idex`  out  1  hold ID/EX.
- `bubble_idex`  out  1  zero control into ID/EX.
- `bubble_exmem`  out  1  zero control into EX/MEM.
- `mc_busy`  out  1  multi-cycle unit computing.
- `mc_done`  out  1  one-cycle pulse: result valid in EX this cycle.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `stall`=1.

## Operation
- Forwarding (combinational, per operand i): if `idex_src_vld[i]`, `exmem_regWrite` and `exmem_rd`==`idex_src[i]`, select 10. Else if `memwb_regWrite` and match, select 01. Else select 00. EX/MEM wins when both match. All registers, including R0, are forwardable.
- Load-use (combinational, gated to FSM IDLE): `idex_memRead & idex_regWrite` and any valid `ifid_src[i]`==`idex_rd` → `stall`=1 and `bubble_idex`=1 for that cycle. The hazard clears naturally on the next cycle.
- Multi-cycle FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY on `idex_mc_start`; the counter loads MC_LAT-2. The unit captures its operands (using `fwd_sel`) in this cycle.
  - BUSY: counter decrements. At 0 → DONE.
  - DONE → IDLE unconditionally.
  - `idex_mc_start` is ignored outside IDLE; the held instruction must not retrigger.
- During BUSY: `stall`=`hold_idex`=`bubble_exmem`=1, `mc_busy`=1. Load-use detection is suppressed.
- During DONE: `mc_done`=1. The result advances into EX/MEM and the holds release.
- `stall_cnt` increments on every cycle with `stall`=1 and saturates at all-ones.

## Timing
- Reset values: FSM IDLE, counter 0, `stall_cnt` 0. All outputs 0 while `rst_n`=0.
- Forwarding and load-use outputs are same-cycle combinational.
- A multi-cycle op issued in IDLE at cycle t: BUSY covers t+1 … t+MC_LAT-1, DONE is at t+MC_LAT, and the next op can issue at t+MC_LAT+1.
- `stall`, `hold_idex` and `bubble_exmem` are registered (decoded from state) for the multi-cycle path. For the load-use path, `stall` is the OR with the combinational hazard.
- Reset asserted mid-BUSY: the FSM immediately returns to IDLE, all holds drop, and no `mc_done` pulse is produced.
- Back-to-back loads each stall one cycle. A load followed by a dependent multi-cycle op stalls one cycle, then issues.

## Configuration
- `FWD_WB_BYPASS_EN` defined: adds output `wb_bypass` (NUM_SRC). Bit i=1 when `memwb_regWrite`, `ifid_src_vld[i]` and `memwb_rd`==`ifid_src[i]`, so decode takes the write-back value (register-file write-through).
- `FWD_WB_BYPASS_EN` undefined: the port is absent. The register file must then write in the first half-cycle.

## Structure
- Package `fwd_pkg`: `fwd_sel` encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB) and the `mc_state_t` enum.
- Sub-module `mc_sequencer`: FSM plus down-counter, parameter MC_LAT, outputs state decodes. Forwarding and load-use logic stays in the top level with a generate loop over NUM_SRC.

## Test plan
- idex_src[0]=3; exmem_rd=3 and memwb_rd=3, both writing → fwd_sel[1:0]=10. Deassert exmem_regWrite → 01.
- idex_src_vld[1]=0 with a matching exmem_rd → fwd_sel[3:2]=00.
- Load to R5 in ID/EX, ifid_src[1]=5 valid → stall=bubble_idex=1 for exactly one cycle, stall_cnt=1.
- idex_mc_start held high with MC_LAT=4 → mc_busy for 3 cycles, mc_done on the 4th, stall_cnt=3, no retrigger.
- rst_n pulsed low in the 2nd BUSY cycle → all outputs 0 asynchronously, IDLE after release, no mc_done.
- Force 2^CNT_W+5 stall cycles (CNT_W=4) → stall_cnt holds at 15.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared encodings for the forwarding / hazard controller: forwarding-select
// codes and the multi-cycle sequencer state type.
package fwd_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mc_state_t;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Pipeline-side bundle for fwd_hazard_ctrl. The pipeline is the master
// (drives register addresses and control flags); the controller is the slave.
// Optional macro FWD_WB_BYPASS_EN adds the decode-stage wb_bypass vector.
interface fwd_hazard_ctrl_if #(
  parameter int unsigned AW      = 3,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 16
);

  logic [NUM_SRC*AW-1:0] ifid_src;
  logic [NUM_SRC-1:0]    ifid_src_vld;
  logic [NUM_SRC*AW-1:0] idex_src;
  logic [NUM_SRC-1:0]    idex_src_vld;
  logic [AW-1:0]         idex_rd;
  logic [AW-1:0]         exmem_rd;
  logic [AW-1:0]         memwb_rd;
  logic                  idex_regWrite;
  logic                  exmem_regWrite;
  logic                  memwb_regWrite;
  logic                  idex_memRead;
  logic                  idex_mc_start;

  logic [NUM_SRC*2-1:0]  fwd_sel;
  logic                  stall;
  logic                  hold_idex;
  logic                  bubble_idex;
  logic                  bubble_exmem;
  logic                  mc_busy;
  logic                  mc_done;
  logic [CNT_W-1:0]      stall_cnt;
`ifdef FWD_WB_BYPASS_EN
  logic [NUM_SRC-1:0]    wb_bypass;
`endif

  modport master (
    output ifid_src, ifid_src_vld, idex_src, idex_src_vld,
    output idex_rd, exmem_rd, memwb_rd,
    output idex_regWrite, exmem_regWrite, memwb_regWrite,
    output idex_memRead, idex_mc_start,
`ifdef FWD_WB_BYPASS_EN
    input  wb_bypass,
`endif
    input  fwd_sel, stall, hold_idex, bubble_idex, bubble_exmem,
    input  mc_busy, mc_done, stall_cnt
  );

  modport slave (
    input  ifid_src, ifid_src_vld, idex_src, idex_src_vld,
    input  idex_rd, exmem_rd, memwb_rd,
    input  idex_regWrite, exmem_regWrite, memwb_regWrite,
    input  idex_memRead, idex_mc_start,
`ifdef FWD_WB_BYPASS_EN
    output wb_bypass,
`endif
    output fwd_sel, stall, hold_idex, bubble_idex, bubble_exmem,
    output mc_busy, mc_done, stall_cnt
  );

endinterface

// File: rtl/fwd_hazard_ctrl_mc_sequencer.sv
// Multi-cycle execute sequencer: IDLE -> BUSY (MC_LAT-1 cycles) -> DONE -> IDLE.
// Start requests outside IDLE are ignored so a held instruction cannot retrigger.
module mc_sequencer
  import fwd_pkg::*;
#(
  parameter int unsigned MC_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic idle,
  output logic busy,
  output logic done
);

  localparam int unsigned CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [CW-1:0] CntLoad = CW'(MC_LAT - 2);

  mc_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and down-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: counter loaded on issue so BUSY lasts exactly MC_LAT-1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StBusy;
          cnt_d   = CntLoad;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State decodes; registered because they come straight from state_q.
  always_comb begin
    idle = (state_q == StIdle);
    busy = (state_q == StBusy);
    done = (state_q == StDone);
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the five-stage pipeline: per-operand
// EX forwarding selects, load-use stall/bubble, multi-cycle unit sequencing
// and a saturating stall-cycle counter.
// Optional macro FWD_WB_BYPASS_EN adds the wb_bypass decode write-through vector.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int unsigned AW      = 3,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned MC_LAT  = 4,
  parameter int unsigned CNT_W   = 16
) (
  input logic              clk,
  input logic              rst_n,
  fwd_hazard_ctrl_if.slave bus
);

  logic [NUM_SRC*2-1:0] fwd_sel_raw;
  logic [NUM_SRC-1:0]   lu_match;
  logic                 mc_idle, mc_busy, mc_done;
  logic                 load_use;
  logic                 stall;
  logic [CNT_W-1:0]     stall_cnt_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [AW-1:0] ex_src;
    logic [AW-1:0] id_src;
    logic [1:0]    sel;
    assign ex_src = bus.idex_src[i*AW +: AW];
    assign id_src = bus.ifid_src[i*AW +: AW];

    // EX/MEM holds the younger result, so it wins over MEM/WB. R0 is forwarded too.
    always_comb begin
      sel = FWD_RF;
      if (bus.idex_src_vld[i]) begin
        if (bus.exmem_regWrite && (bus.exmem_rd == ex_src)) begin
          sel = FWD_EXMEM;
        end else if (bus.memwb_regWrite && (bus.memwb_rd == ex_src)) begin
          sel = FWD_MEMWB;
        end
      end
    end

    assign fwd_sel_raw[i*2 +: 2] = sel;
    assign lu_match[i] = bus.ifid_src_vld[i] && (id_src == bus.idex_rd);

`ifdef FWD_WB_BYPASS_EN
    assign bus.wb_bypass[i] = rst_n && bus.memwb_regWrite && bus.ifid_src_vld[i]
                              && (bus.memwb_rd == id_src);
`endif
  end

  mc_sequencer #(
    .MC_LAT (MC_LAT)
  ) u_mc_sequencer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bus.idex_mc_start),
    .idle  (mc_idle),
    .busy  (mc_busy),
    .done  (mc_done)
  );

  // Combinational outputs; forced low while reset is asserted.
  always_comb begin
    load_use = rst_n && mc_idle && bus.idex_memRead && bus.idex_regWrite && (|lu_match);
    stall    = mc_busy || load_use;

    bus.fwd_sel      = rst_n ? fwd_sel_raw : '0;
    bus.stall        = stall;
    bus.hold_idex    = mc_busy;
    bus.bubble_idex  = load_use;
    bus.bubble_exmem = mc_busy;
    bus.mc_busy      = mc_busy;
    bus.mc_done      = mc_done;
    bus.stall_cnt    = stall_cnt_q;
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

endmodule
